// File: rtl/pal_sop_pkg.sv
// ---------------------------------------------------------------------------
// pal_sop_pkg
// Shared definitions for the programmable sum-of-products array:
//   - cfg_state_e      : configuration FSM states (RUN / LOAD / COMMIT)
//   - DEF_* constants  : default geometry and the power-on configuration
//   - and_off / or_off / inv_off : bit offsets of each field inside the
//                        flat configuration vector
//
// Configuration vector layout (LSB first):
//   [t*2N_IN +: 2N_IN]     AND mask of term t; bit i picks in[i],
//                          bit N_IN+i picks ~in[i]
//   [A + o*N_TERM +: N_TERM] OR mask of output o, A = N_TERM*2*N_IN
//   [A + N_OUT*N_TERM + o]   invert bit of output o
// ---------------------------------------------------------------------------
package pal_sop_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } cfg_state_e;

    localparam int DEF_N_IN     = 6;
    localparam int DEF_N_TERM   = 4;
    localparam int DEF_N_OUT    = 2;
    localparam int DEF_CFG_BITS = DEF_N_TERM * 2 * DEF_N_IN + DEF_N_OUT * (DEF_N_TERM + 1);

    // o0 = i0&i1&i2 | i3&i4&i5 ; o1 = i0&i1 | i2&i3
    localparam logic [DEF_CFG_BITS-1:0] DEF_RST_CFG = 58'h0C3_00C0_0303_8007;

    function automatic int and_off(input int t, input int n_in);
        return t * 2 * n_in;
    endfunction

    function automatic int or_off(input int o, input int n_in, input int n_term);
        return n_term * 2 * n_in + o * n_term;
    endfunction

    function automatic int inv_off(input int o, input int n_in, input int n_term, input int n_out);
        return n_term * 2 * n_in + n_out * n_term + o;
    endfunction

endpackage

// File: rtl/pal_sop_array_cfg.sv
// ---------------------------------------------------------------------------
// pal_sop_cfg
// Serial configuration loader for the sum-of-products array. Owns the
// RUN/LOAD/COMMIT FSM, the bit counter, the shadow register and the active
// configuration register.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   cfg_start_i    begin (or restart) a serial load
//   cfg_valid_i    cfg_bit_i is valid this cycle (only used in LOAD)
//   cfg_bit_i      serial data, first bit sent ends up as the MSB
//   pipe_empty_i   datapath has no sample in flight
//   active_cfg_o   configuration currently used by the datapath
//   state_o        FSM state, for the datapath and for observation
//   cfg_busy_o     high in LOAD or COMMIT
//   cfg_done_o     one-cycle pulse, high in the first cycle the new
//                  configuration is active
// ---------------------------------------------------------------------------
module pal_sop_cfg
    import pal_sop_pkg::*;
#(
    parameter int                  CFG_BITS = DEF_CFG_BITS,
    parameter logic [CFG_BITS-1:0] RST_CFG  = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_start_i,
    input  logic                cfg_valid_i,
    input  logic                cfg_bit_i,
    input  logic                pipe_empty_i,
    output logic [CFG_BITS-1:0] active_cfg_o,
    output cfg_state_e          state_o,
    output logic                cfg_busy_o,
    output logic                cfg_done_o
);

    localparam int               CNT_W    = $clog2(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);

    cfg_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic                done_q, done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (cfg_start_i) begin
                    state_d  = ST_LOAD;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            ST_LOAD: begin
                // A restart wins over a same-cycle bit; that bit is dropped.
                if (cfg_start_i) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (cfg_valid_i) begin
                    shadow_d = {shadow_q[CFG_BITS-2:0], cfg_bit_i};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_COMMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                // Swap only once the pipe is empty so no sample ever sees
                // a mix of old and new configuration.
                if (cfg_start_i) begin
                    state_d  = ST_LOAD;
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (pipe_empty_i) begin
                    active_d = shadow_q;
                    done_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= RST_CFG;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign active_cfg_o = active_q;
    assign state_o      = state_q;
    assign cfg_busy_o   = (state_q != ST_RUN);
    assign cfg_done_o   = done_q;

endmodule

// File: rtl/pal_sop_array.sv
// ---------------------------------------------------------------------------
// pal_sop_array
// Run-time reconfigurable sum-of-products logic array with a two-stage
// registered datapath. Stage 1 registers the product terms, stage 2
// registers the OR/invert result.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   cfg_start/valid/bit      serial configuration port (MSB first)
//   cfg_busy, cfg_done       configuration status
//   in_valid/in_ready/in_data     input sample stream
//   out_valid/out_ready/out_data  result stream
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its data stable until the
// transfer; out_data/out_valid stay frozen while out_valid & ~out_ready.
// in_ready is low while a configuration load/commit is pending or the
// output stage is stalled. Accepting at cycle n gives out_valid at n+2.
// ---------------------------------------------------------------------------
module pal_sop_array
    import pal_sop_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int N_TERM = DEF_N_TERM,
    parameter int N_OUT  = DEF_N_OUT,
    parameter logic [N_TERM*2*N_IN+N_OUT*(N_TERM+1)-1:0] RST_CFG = DEF_RST_CFG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_busy,
    output logic             cfg_done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data
);

    localparam int CFG_BITS = N_TERM * 2 * N_IN + N_OUT * (N_TERM + 1);

    logic [CFG_BITS-1:0] active_cfg;
    cfg_state_e          cfg_state;

    logic                stall;
    logic                accept;
    logic [N_TERM-1:0]   term_d;
    logic [N_TERM-1:0]   s1_terms_q;
    logic                s1_valid_q;
    logic [N_OUT-1:0]    out_d;
    logic [N_OUT-1:0]    out_data_q;
    logic                out_valid_q;

    pal_sop_cfg #(
        .CFG_BITS (CFG_BITS),
        .RST_CFG  (RST_CFG)
    ) u_cfg (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_start_i  (cfg_start),
        .cfg_valid_i  (cfg_valid),
        .cfg_bit_i    (cfg_bit),
        .pipe_empty_i (~s1_valid_q & ~out_valid_q),
        .active_cfg_o (active_cfg),
        .state_o      (cfg_state),
        .cfg_busy_o   (cfg_busy),
        .cfg_done_o   (cfg_done)
    );

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = (cfg_state == ST_RUN) & ~stall;
    assign accept   = in_valid & in_ready;

    // Product terms: unselected literals are forced to 1, so an empty AND
    // mask yields a term of 1.
    always_comb begin
        logic [2*N_IN-1:0] and_mask;
        term_d   = '0;
        and_mask = '0;
        for (int t = 0; t < N_TERM; t++) begin
            and_mask  = active_cfg[and_off(t, N_IN) +: 2*N_IN];
            term_d[t] = &(~and_mask | {~in_data, in_data});
        end
    end

    // OR plane plus optional inversion; an empty OR mask gives 0 before
    // the invert bit is applied.
    always_comb begin
        logic [N_TERM-1:0] or_mask;
        out_d   = '0;
        or_mask = '0;
        for (int o = 0; o < N_OUT; o++) begin
            or_mask  = active_cfg[or_off(o, N_IN, N_TERM) +: N_TERM];
            out_d[o] = (|(or_mask & s1_terms_q)) ^ active_cfg[inv_off(o, N_IN, N_TERM, N_OUT)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_terms_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (!stall) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_terms_q <= term_d;
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= out_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_pal_sop_array.sv
// ---------------------------------------------------------------------------
// tb_pal_sop_array
// Directed bench for pal_sop_array. Expected outputs are hand-computed from
// the reset configuration (o0 = i0&i1&i2 | i3&i4&i5, o1 = i0&i1 | i2&i3) and
// from two hand-built configurations:
//   CFG_A: term0 = i0, o0 = ~term0 (inverted), o1 = empty OR, inverted -> 1
//   CFG_B: term0 = ~i5, term1 = i1 & ~i0, o0 = term0, o1 = term1
// ---------------------------------------------------------------------------
module tb_pal_sop_array;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_bit;
    logic       cfg_busy;
    logic       cfg_done;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_data;

    localparam logic [57:0] CFG_RST = 58'h0C3_00C0_0303_8007;
    localparam logic [57:0] CFG_A   = 58'h301_0000_0000_0001;
    localparam logic [57:0] CFG_B   = 58'h021_0000_0004_2800;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] cur_exp;
    logic       acc;
    int         emits;

    pal_sop_array dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Checker
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs were set at the falling edge; just before the
    // rising edge, record the transfers that edge will perform.
    task automatic step();
        logic [1:0] e;
        #1;
        acc = 1'b0;
        if (!rst) begin
            if (out_valid && out_ready) begin
                emits++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_unexpected: observed=%0h expected=none", out_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_out_data", 64'(out_data), 64'(e));
                end
            end
            if (in_valid && in_ready) begin
                acc = 1'b1;
                exp_q.push_back(cur_exp);
            end
        end
        @(negedge clk);
    endtask

    // Driver tasks
    task automatic do_reset();
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cur_exp   = '0;
        step();
        step();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic send(input logic [5:0] d, input logic [1:0] e);
        in_valid = 1'b1;
        in_data  = d;
        cur_exp  = e;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc) break;
        end
        chk("send_accepted", 64'(acc), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            step();
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic cfg_begin();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic shift_bits(input logic [57:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = v[57-i];
            step();
        end
        cfg_valid = 1'b0;
    endtask

    // Directed sequence
    initial begin
        logic [5:0] vec_t[8];
        logic [1:0] exp_t[8];
        int         done_cnt;
        int         emits_at_done;

        vec_t = '{6'b001100, 6'b000111, 6'b111000, 6'b000011,
                  6'b000000, 6'b111111, 6'b010101, 6'b111100};
        exp_t = '{2'b10, 2'b11, 2'b01, 2'b10,
                  2'b00, 2'b11, 2'b00, 2'b11};

        // 1: reset state and first-sample latency
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_cfg_busy", 64'(cfg_busy), 64'(0));
        chk("rst_cfg_done", 64'(cfg_done), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_data  = 6'b000111;
        cur_exp  = 2'b11;
        step();
        chk("t1_accept", 64'(acc), 64'(1));
        in_valid = 1'b0;
        chk("t1_out_valid_n1", 64'(out_valid), 64'(0));
        step();
        chk("t1_out_valid_n2", 64'(out_valid), 64'(1));
        chk("t1_out_data", 64'(out_data), 64'(2'b11));
        drain(5);

        // 2: full-throughput stream of 8 samples
        do_reset();
        emits = 0;
        for (int k = 0; k < 8; k++) begin
            send(vec_t[k], exp_t[k]);
            if (k == 1) chk("t2_first_out", 64'({out_valid, out_data}), 64'(3'b110));
        end
        step();
        step();
        chk("t2_back_to_back", 64'(emits), 64'(8));
        chk("t2_queue_empty", 64'(exp_q.size()), 64'(0));

        // 3: downstream stall with 3 samples offered
        emits     = 0;
        out_ready = 1'b0;
        send(6'b000111, 2'b11);
        send(6'b111000, 2'b01);
        in_valid = 1'b1;
        in_data  = 6'b000011;
        cur_exp  = 2'b10;
        for (int i = 0; i < 3; i++) begin
            chk("t3_in_ready_low", 64'(in_ready), 64'(0));
            chk("t3_out_valid_held", 64'(out_valid), 64'(1));
            chk("t3_out_data_stable", 64'(out_data), 64'(2'b11));
            step();
            chk("t3_no_accept", 64'(acc), 64'(0));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (acc) break;
        end
        chk("t3_third_accepted", 64'(acc), 64'(1));
        in_valid = 1'b0;
        drain(10);
        chk("t3_emit_count", 64'(emits), 64'(3));

        // 4: load CFG_A while two old-config samples sit in the pipe
        out_ready = 1'b0;
        send(6'b000111, 2'b11);
        send(6'b001100, 2'b10);
        cfg_begin();
        chk("t4_busy_load", 64'(cfg_busy), 64'(1));
        chk("t4_in_ready_load", 64'(in_ready), 64'(0));
        shift_bits(CFG_A, 58);
        step();
        step();
        chk("t4_busy_commit", 64'(cfg_busy), 64'(1));
        chk("t4_no_early_done", 64'(cfg_done), 64'(0));
        chk("t4_held_data", 64'(out_data), 64'(2'b11));
        emits         = 0;
        done_cnt      = 0;
        emits_at_done = -1;
        out_ready     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (cfg_done) begin
                if (done_cnt == 0) emits_at_done = emits;
                done_cnt++;
            end
        end
        chk("t4_done_single_pulse", 64'(done_cnt), 64'(1));
        chk("t4_drained_before_commit", 64'(emits_at_done), 64'(2));
        chk("t4_busy_cleared", 64'(cfg_busy), 64'(0));
        send(6'b000000, 2'b11);
        send(6'b000001, 2'b10);
        drain(10);

        // 5: restart mid-load, with a bit on the restart cycle, then CFG_B
        cfg_begin();
        shift_bits(CFG_RST, 30);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        chk("t5_busy_restart", 64'(cfg_busy), 64'(1));
        shift_bits(CFG_B, 58);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cfg_done) begin
                done_cnt++;
                break;
            end
        end
        chk("t5_done_seen", 64'(done_cnt), 64'(1));
        send(6'b000010, 2'b11);
        send(6'b100001, 2'b00);
        send(6'b000111, 2'b01);
        drain(10);

        // 6: reset during a load restores the reset configuration
        cfg_begin();
        shift_bits(CFG_B, 40);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("t6_busy_after_rst", 64'(cfg_busy), 64'(0));
        chk("t6_done_after_rst", 64'(cfg_done), 64'(0));
        chk("t6_in_ready", 64'(in_ready), 64'(1));
        send(6'b000111, 2'b11);
        send(6'b001100, 2'b10);
        drain(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
